maze_wall_renderer: RTL

// - Parametrised successor to the base-station maze drawer. Sits between the Arduino radio bridge and the VGA framebuffer write port.
// - On reset, paints background plus grid lines. Then queues cell reports in a FIFO; each report carries a position, a 4-bit wall mask and a strobe.
// - Draws every set wall of a report, then a visited mark at the cell centre. Output is one pixel per clock with an explicit write enable.

---
 rtl/maze_wall_renderer_pkg.sv | 40 ++++
 rtl/maze_wall_renderer_sync_fifo.sv | 62 ++++++
 rtl/maze_wall_renderer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/maze_wall_renderer_pkg.sv
// Shared definitions for the maze wall renderer.
// - Framebuffer colour codes.
// - Wall-mask bit indices within the 4-bit WALLS field (N=3, E=2, S=1, W=0).
// - FSM state encoding.
// - Helper that picks the next wall state to draw.
package maze_wall_renderer_pkg;

  localparam logic [3:0] BG_COLOR   = 4'h0;
  localparam logic [3:0] GRID_COLOR = 4'h1;
  localparam logic [3:0] WALL_COLOR = 4'h2;
  localparam logic [3:0] MARK_COLOR = 4'h4;

  localparam int WALL_N = 3;
  localparam int WALL_E = 2;
  localparam int WALL_S = 1;
  localparam int WALL_W = 0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_N,
    ST_E,
    ST_S,
    ST_W,
    ST_MARK
  } state_e;

  // Walls are drawn in N, E, S, W order. Callers mask off the walls already
  // drawn, so the first remaining set bit picks the next state. Clear bits
  // cost zero cycles.
  function automatic state_e first_wall(input logic [3:0] m);
    if (m[WALL_N])      return ST_N;
    else if (m[WALL_E]) return ST_E;
    else if (m[WALL_S]) return ST_S;
    else if (m[WALL_W]) return ST_W;
    else                return ST_MARK;
  endfunction

endpackage

// File: rtl/maze_wall_renderer_sync_fifo.sv
// Synchronous FIFO with registered read data.
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset (control only)
//   push_i, wdata_i write request and data
//   pop_i           read request; rdata_o is valid the cycle after the pop
//   full_o, empty_o occupancy flags
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module maze_wall_renderer_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage and read register carry no reset; occupancy is tracked above.
  // When full with simultaneous push/pop the pointers coincide, and the
  // read picks up the old entry before it is overwritten.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    if (pop_ok)  rdata_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/maze_wall_renderer.sv
// Maze wall renderer: turns cell reports from the radio bridge into
// framebuffer pixel writes, one pixel per clock.
// Ports:
//   CLK, RESET     clock, synchronous active-high reset
//   ARDUINO_IN     asynchronous report {UPDATE, WALLS[3:0], POS_Y, POS_X}
//   VGA_PIXEL_X/Y  framebuffer write coordinate
//   PIXEL_OUT      write colour
//   W_EN           write strobe
//   BUSY           painting, drawing, or reports pending
//   OVERFLOW       sticky: a report was dropped because the FIFO was full
// After reset the whole screen is painted with background and grid lines.
// Each report then draws its set walls (N, E, S, W) and a visited mark.
module maze_wall_renderer
  import maze_wall_renderer_pkg::*;
#(
  parameter int COORD_W    = 4,
  parameter int GRID_COLS  = 10,
  parameter int GRID_ROWS  = 10,
  parameter int CELL_PX    = 30,
  parameter int MARK_PX    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [2*COORD_W+4:0] ARDUINO_IN,
  output logic [9:0]           VGA_PIXEL_X,
  output logic [9:0]           VGA_PIXEL_Y,
  output logic [3:0]           PIXEL_OUT,
  output logic                 W_EN,
  output logic                 BUSY,
  output logic                 OVERFLOW
);

  localparam int IN_W = 2*COORD_W + 5;
  localparam int REP_W = 2*COORD_W + 4;
  localparam logic [9:0] SW_LAST   = 10'(GRID_COLS*CELL_PX);
  localparam logic [9:0] SH_LAST   = 10'(GRID_ROWS*CELL_PX);
  localparam logic [9:0] CELL_P    = 10'(CELL_PX);
  localparam logic [9:0] CELL_LAST = 10'(CELL_PX-1);
  localparam logic [9:0] MARK_LAST = 10'(MARK_PX-1);
  localparam logic [9:0] MARK_OFF  = 10'(CELL_PX/2 - MARK_PX/2);

  // Input synchroniser and UPDATE rising-edge detect
  logic [IN_W-1:0]    sync1_q, sync2_q;
  logic               upd_prev_q;
  logic               upd_rise;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic               in_range;
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [REP_W-1:0]   rd_data;
  logic               ovf_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      upd_prev_q <= 1'b0;
    end else begin
      sync1_q    <= ARDUINO_IN;
      sync2_q    <= sync1_q;
      upd_prev_q <= sync2_q[IN_W-1];
    end
  end

  assign upd_rise = sync2_q[IN_W-1] && !upd_prev_q;
  assign pos_x    = sync2_q[COORD_W-1:0];
  assign pos_y    = sync2_q[2*COORD_W-1:COORD_W];
  assign in_range = (32'(pos_x) < GRID_COLS) && (32'(pos_y) < GRID_ROWS);
  assign push     = upd_rise && in_range;

  // Report queue
  maze_wall_renderer_sync_fifo #(
    .WIDTH (REP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (sync2_q[REP_W-1:0]),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) ovf_q <= 1'b0;
    else if (push && fifo_full && !pop) ovf_q <= 1'b1;
  end

  // Drawing FSM with registered pixel outputs
  state_e     state_q;
  state_e     wall_next;
  logic [9:0] ix_q, iy_q, phx_q, phy_q;
  logic [9:0] step_q, mx_q, my_q;
  logic [9:0] ox_q, oy_q;
  logic [3:0] mask_q;
  logic [9:0] wall_x, wall_y;
  logic [9:0] x_q, y_q;
  logic [3:0] pix_q;
  logic       wen_q;

  assign pop = (state_q == ST_IDLE) && !fifo_empty;

  // Coordinate of the current wall pixel and the state after this wall.
  always_comb begin
    wall_x    = ox_q;
    wall_y    = oy_q;
    wall_next = ST_MARK;
    case (state_q)
      ST_N: begin
        wall_x    = ox_q + step_q;
        wall_next = first_wall(mask_q & 4'b0111);
      end
      ST_E: begin
        wall_x    = ox_q + CELL_P;
        wall_y    = oy_q + step_q;
        wall_next = first_wall(mask_q & 4'b0011);
      end
      ST_S: begin
        wall_x    = ox_q + step_q;
        wall_y    = oy_q + CELL_P;
        wall_next = first_wall(mask_q & 4'b0001);
      end
      ST_W: begin
        wall_y    = oy_q + step_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_INIT;
      ix_q    <= '0;
      iy_q    <= '0;
      phx_q   <= '0;
      phy_q   <= '0;
      step_q  <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= BG_COLOR;
      wen_q   <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      case (state_q)
        // Full-screen raster; phase counters track position within a cell
        // so grid lines are found without a modulo.
        ST_INIT: begin
          x_q   <= ix_q;
          y_q   <= iy_q;
          pix_q <= (phx_q == 10'd0 || phy_q == 10'd0) ? GRID_COLOR : BG_COLOR;
          wen_q <= 1'b1;
          if (ix_q == SW_LAST) begin
            ix_q  <= '0;
            phx_q <= '0;
            if (iy_q == SH_LAST) begin
              state_q <= ST_IDLE;
            end else begin
              iy_q  <= iy_q + 10'd1;
              phy_q <= (phy_q == CELL_LAST) ? 10'd0 : phy_q + 10'd1;
            end
          end else begin
            ix_q  <= ix_q + 10'd1;
            phx_q <= (phx_q == CELL_LAST) ? 10'd0 : phx_q + 10'd1;
          end
        end
        ST_IDLE: begin
          if (pop) state_q <= ST_LOAD;
        end
        // FIFO read data became valid this cycle.
        ST_LOAD: begin
          ox_q    <= 10'(rd_data[COORD_W-1:0]) * CELL_P;
          oy_q    <= 10'(rd_data[2*COORD_W-1:COORD_W]) * CELL_P;
          mask_q  <= rd_data[REP_W-1:2*COORD_W];
          step_q  <= '0;
          mx_q    <= '0;
          my_q    <= '0;
          state_q <= first_wall(rd_data[REP_W-1:2*COORD_W]);
        end
        ST_N, ST_E, ST_S, ST_W: begin
          x_q   <= wall_x;
          y_q   <= wall_y;
          pix_q <= WALL_COLOR;
          wen_q <= 1'b1;
          if (step_q == CELL_P) begin
            step_q  <= '0;
            state_q <= wall_next;
          end else begin
            step_q <= step_q + 10'd1;
          end
        end
        ST_MARK: begin
          x_q   <= ox_q + MARK_OFF + mx_q;
          y_q   <= oy_q + MARK_OFF + my_q;
          pix_q <= MARK_COLOR;
          wen_q <= 1'b1;
          if (mx_q == MARK_LAST) begin
            mx_q <= '0;
            if (my_q == MARK_LAST) state_q <= ST_IDLE;
            else my_q <= my_q + 10'd1;
          end else begin
            mx_q <= mx_q + 10'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign VGA_PIXEL_X = x_q;
  assign VGA_PIXEL_Y = y_q;
  assign PIXEL_OUT   = pix_q;
  assign W_EN        = wen_q;
  assign OVERFLOW    = ovf_q;
  // wen_q keeps BUSY high through the final registered write.
  assign BUSY        = (state_q != ST_IDLE) || !fifo_empty || wen_q;

endmodule
